// File: rtl/fifo_pack_8to16_if.sv
// Byte-write / word-read handshake bundle for fifo_pack_8to16.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_pack_8to16_if #(
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  wr;
  logic [7:0]            w_data;
  logic                  rd;
  logic [15:0]           r_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH+1:0] count;

  modport master (
    output wr, w_data, rd,
    input  r_data, full, empty, count
  );

  modport slave (
    input  wr, w_data, rd,
    output r_data, full, empty, count
  );
endinterface

// File: rtl/fifo_pack_8to16.sv
// Byte-in / word-out first-word-fall-through FIFO. Bytes are packed low lane first
// into 16-bit words; a lone trailing byte stays hidden until its partner arrives.
module fifo_pack_8to16 #(
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  fifo_pack_8to16_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] FullCount = {1'b1, {(ADDR_WIDTH + 1){1'b0}}};

  logic [15:0]           mem_q [Depth];
  logic [ADDR_WIDTH+1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH+1:0] count;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  full, empty, wr_acc, rd_acc, we_lo, we_hi;

  always_comb begin
    // Flags come only from the pointer registers, never from this cycle's wr/rd.
    count    = wr_ptr_q - {rd_ptr_q, 1'b0};
    full     = (count == FullCount);
    empty    = (count[ADDR_WIDTH+1:1] == '0);
    wr_acc   = bus.wr & ~full;
    rd_acc   = bus.rd & ~empty;
    wr_idx   = wr_ptr_q[ADDR_WIDTH:1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    we_lo    = 1'b0;
    we_hi    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + (ADDR_WIDTH + 2)'(1);
        we_lo    = ~wr_ptr_q[0];
        we_hi    = wr_ptr_q[0];
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left uncleared; gating by reset keeps ignored writes inert.
  always_ff @(posedge clk) begin
    if (reset && we_lo) mem_q[wr_idx][7:0]  <= bus.w_data;
    if (reset && we_hi) mem_q[wr_idx][15:8] <= bus.w_data;
  end

  assign bus.r_data = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.count  = count;
endmodule

// File: tb/tb_fifo_pack_8to16.sv
// Scenario bench for fifo_pack_8to16 at ADDR_WIDTH=3 with a byte-queue scoreboard.
module tb_fifo_pack_8to16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sb[$];

  fifo_pack_8to16_if #(.ADDR_WIDTH(3)) bus ();

  fifo_pack_8to16 #(.ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the scoreboard follows the acceptance rules from pre-edge state.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic rn, input logic fl);
    int  n;
    bit  wa, ra;
    n  = sb.size();
    wa = w && (n < 16);
    ra = r && (n >= 2);
    bus.wr = w; bus.w_data = d; bus.rd = r; reset = rn; flush = fl;
    @(posedge clk); #1;
    bus.wr = 1'b0; bus.rd = 1'b0; reset = 1'b1; flush = 1'b0;
    if (!rn || fl) sb.delete();
    else begin
      if (ra) begin void'(sb.pop_front()); void'(sb.pop_front()); end
      if (wa) sb.push_back(d);
    end
  endtask

  function automatic logic [15:0] sb_word();
    return (sb.size() >= 2) ? {sb[1], sb[0]} : 16'hxxxx;
  endfunction

  task automatic test_reset();
    step(0, 8'h00, 0, 0, 0);
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got c=%0d e=%b f=%b want c=0 e=1 f=0",
               bus.count, bus.empty, bus.full);
    end
  endtask

  task automatic test_basic();
    step(1, 8'h11, 0, 1, 0);
    checks++;
    if (bus.count !== 5'd1 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL basic_one got c=%0d e=%b want c=1 e=1", bus.count, bus.empty);
    end
    step(1, 8'h22, 0, 1, 0);
    checks++;
    if (bus.count !== 5'd2 || bus.empty !== 1'b0 || bus.r_data !== 16'h2211) begin
      errors++;
      $display("FAIL basic_word got c=%0d e=%b d=%h want c=2 e=0 d=2211",
               bus.count, bus.empty, bus.r_data);
    end
    step(0, 8'h00, 1, 1, 0);
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL basic_pop got c=%0d e=%b want c=0 e=1", bus.count, bus.empty);
    end
  endtask

  task automatic test_full();
    logic [15:0] exp;
    test_reset();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.full !== 1'b0) begin
        errors++; $display("FAIL full_early at %0d got %b want 0", i, bus.full);
      end
      step(1, 8'(i), 0, 1, 0);
    end
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
      errors++; $display("FAIL full_set got f=%b c=%0d want f=1 c=16", bus.full, bus.count);
    end
    step(1, 8'hAA, 0, 1, 0);
    checks++;
    if (bus.count !== 5'd16) begin
      errors++; $display("FAIL full_drop got c=%0d want 16", bus.count);
    end
    for (int k = 0; k < 8; k++) begin
      exp = {8'(2 * k + 1), 8'(2 * k)};
      checks++;
      if (bus.r_data !== exp || sb_word() !== exp) begin
        errors++; $display("FAIL full_read%0d got %h want %h", k, bus.r_data, exp);
      end
      step(0, 8'h00, 1, 1, 0);
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      errors++; $display("FAIL full_drain got e=%b c=%0d want e=1 c=0", bus.empty, bus.count);
    end
  endtask

  task automatic test_odd_byte();
    test_reset();
    step(1, 8'hA1, 0, 1, 0);
    step(1, 8'hB2, 0, 1, 0);
    step(1, 8'hC3, 0, 1, 0);
    checks++;
    if (bus.r_data !== 16'hB2A1) begin
      errors++; $display("FAIL odd_first got %h want b2a1", bus.r_data);
    end
    step(0, 8'h00, 1, 1, 0);
    checks++;
    if (bus.count !== 5'd1 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL odd_hidden got c=%0d e=%b want c=1 e=1", bus.count, bus.empty);
    end
    step(0, 8'h00, 1, 1, 0);
    checks++;
    if (bus.count !== 5'd1) begin
      errors++; $display("FAIL odd_rd_empty got c=%0d want 1", bus.count);
    end
    step(1, 8'hD4, 0, 1, 0);
    checks++;
    if (bus.empty !== 1'b0 || bus.r_data !== 16'hD4C3) begin
      errors++; $display("FAIL odd_pair got e=%b d=%h want e=0 d=d4c3", bus.empty, bus.r_data);
    end
  endtask

  task automatic test_simultaneous();
    test_reset();
    step(1, 8'h01, 0, 1, 0);
    step(1, 8'h02, 0, 1, 0);
    step(1, 8'h55, 1, 1, 0);
    checks++;
    if (bus.count !== 5'd1 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL sim_c2 got c=%0d e=%b want c=1 e=1", bus.count, bus.empty);
    end
    step(1, 8'h66, 0, 1, 0);
    checks++;
    if (bus.r_data !== 16'h6655) begin
      errors++; $display("FAIL sim_c2_data got %h want 6655", bus.r_data);
    end
    test_reset();
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 1, 0);
    step(1, 8'hEE, 1, 1, 0);
    checks++;
    if (bus.count !== 5'd14 || bus.full !== 1'b0) begin
      errors++; $display("FAIL sim_c16 got c=%0d f=%b want c=14 f=0", bus.count, bus.full);
    end
    for (int k = 1; k < 8; k++) begin
      checks++;
      if (bus.r_data !== sb_word()) begin
        errors++; $display("FAIL sim_c16_read%0d got %h want %h", k, bus.r_data, sb_word());
      end
      step(0, 8'h00, 1, 1, 0);
    end
    test_reset();
    step(1, 8'h31, 0, 1, 0);
    step(1, 8'h42, 1, 1, 0);
    checks++;
    if (bus.count !== 5'd2 || bus.r_data !== 16'h4231) begin
      errors++; $display("FAIL sim_c1 got c=%0d d=%h want c=2 d=4231", bus.count, bus.r_data);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    int nb = 0;
    int nw = 0;
    test_reset();
    for (int i = 0; i < 4; i++) begin step(1, 8'(nb), 0, 1, 0); nb++; end
    while (nw < 20) begin
      if (nb < 40) begin
        step(1, 8'(nb), 0, 1, 0); nb++;
        step(1, 8'(nb), 0, 1, 0); nb++;
      end
      exp = {8'(2 * nw + 1), 8'(2 * nw)};
      checks++;
      if (bus.r_data !== exp || sb_word() !== exp || bus.count !== 5'(sb.size())) begin
        errors++;
        $display("FAIL wrap_word%0d got %h c=%0d want %h c=%0d",
                 nw, bus.r_data, bus.count, exp, sb.size());
      end
      step(0, 8'h00, 1, 1, 0); nw++;
    end
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL wrap_end got c=%0d e=%b want c=0 e=1", bus.count, bus.empty);
    end
  endtask

  task automatic test_clear(input bit use_flush);
    test_reset();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 1, 0);
    step(1, 8'h99, 0, use_flush ? 1'b1 : 1'b0, use_flush);
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL clear%0d_state got c=%0d e=%b f=%b want c=0 e=1 f=0",
               use_flush, bus.count, bus.empty, bus.full);
    end
    step(1, 8'h7E, 0, 1, 0);
    checks++;
    if (bus.count !== 5'd1 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL clear%0d_one got c=%0d want 1", use_flush, bus.count);
    end
    step(1, 8'h7F, 0, 1, 0);
    checks++;
    if (bus.r_data !== 16'h7F7E || bus.empty !== 1'b0) begin
      errors++; $display("FAIL clear%0d_word got %h want 7f7e", use_flush, bus.r_data);
    end
  endtask

  initial begin
    bus.wr = 1'b0; bus.rd = 1'b0; bus.w_data = 8'h00;
    test_reset();
    test_basic();
    test_full();
    test_odd_byte();
    test_simultaneous();
    test_wrap();
    test_clear(1'b0);
    test_clear(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
